// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, legal parameter ranges,
// and the parity helper (also used by the receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MAX = 2;

  // Wide enough to count 0..DATA_BITS_MAX-1.
  localparam int BIT_CNT_W = 4;

  // Payload narrower than DATA_BITS_MAX is zero-extended by the caller,
  // which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] payload,
                                      input logic odd);
    return (^payload) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count (tick) and the cycle just before it (pre_tick).
// The counter is held at zero whenever enable is low.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic enable,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // Free-running bit-time counter, cleared while disabled, wraps on terminal count.
  always_ff @(posedge sys_clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick     = enable && (cnt == TERM);
  assign pre_tick = enable && (cnt == PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload LSB first,
// optional parity bit, STOP_BITS stop bits. load/ready handshake with
// busy/done status; tx idles high.
// Optional parity is enabled by defining UART_TX_PARITY_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $fatal(1, "uart_tx_frame: DATA_BITS=%0d out of range", DATA_BITS);
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $fatal(1, "uart_tx_frame: CLKS_PER_BIT=%0d must be >= 2", CLKS_PER_BIT);
  end
  if (STOP_BITS < 1 || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_frame: STOP_BITS=%0d out of range", STOP_BITS);
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $fatal(1, "uart_tx_frame: PARITY_ODD=%0d must be 0 or 1", PARITY_ODD);
  end

  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t              state;
  logic [DATA_BITS-1:0]   shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   stop_cnt;
  logic                   tick;
  logic                   pre_tick;
  logic                   baud_en;
  logic                   last_stop;
`ifdef UART_TX_PARITY_EN
  logic                   par_bit;
`endif

  assign baud_en   = (state != IDLE);
  assign last_stop = (state == STOP) && (stop_cnt == STOP_LAST);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .sys_clk (sys_clk),
    .reset   (reset),
    .enable  (baud_en),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // Frame sequencer: state, shift register, counters and registered outputs.
  // done is registered one cycle ahead (pre_tick) so it lands on the final
  // cycle of the last stop bit rather than the cycle after it.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      done <= last_stop && pre_tick;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (load && ready) begin
            shreg    <= data_in;
            state    <= START;
            tx       <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= parity_bit(DATA_BITS_MAX'(data_in), PARITY_ODD[0]);
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the next-generation replacement for the fixed 7-bit transmitter.
- Configurable data width, baud divisor and stop-bit count.
- load/ready handshake and busy/done status.
- Optional parity bit.
- Drives the serial line consumed by the UART receiver; single sys_clk domain.

Parameters:
- DATA_BITS, 7, payload bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, sys_clk cycles per serial bit; legal >= 2.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  request to send data_in; accepted when load && ready.
- data_in  input  DATA_BITS  payload; sampled only on acceptance.
- ready  output  1  high only in IDLE; transmitter can accept.
- busy  output  1  high while a frame is on the line (START through STOP).
- done  output  1  one-cycle pulse at frame completion.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (sync, wins over everything): tx=1, ready=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - tx=1, ready=1.
  - On load && ready: latch data_in into the shift register and enter START; ready falls next cycle.
  - load while not ready is ignored; it is not queued.
- Latency: tx goes low the first cycle after acceptance.
- Each bit holds tx for exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1.
  - Counter wraps and the state/bit advances on the terminal count.
- START: tx=0 for one bit time, then DATA.
- DATA:
  - LSB first; the shift register shifts right on each bit boundary.
  - Bit counter counts 0..DATA_BITS-1; after the last bit go to PARITY (if enabled) or STOP.
- STOP:
  - tx=1 for STOP_BITS bit times.
  - done=1 on the final cycle of the last stop bit.
  - Next cycle returns to IDLE: ready=1, busy=0.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- busy is high from the first START cycle through the last STOP cycle inclusive.
- Back-to-back frames:
  - With load held high, the next acceptance occurs in the single IDLE cycle.
  - Minimum inter-frame idle-high time is therefore exactly 1 sys_clk cycle beyond the stop bits.
- data_in changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: tx=1 on the next cycle, frame aborted, no done pulse, ready=1.
- Illegal parameters: an elaboration-time check must fail the build.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA, lasting one bit time.
  - Parity bit = XOR of the latched payload, inverted when PARITY_ODD=1.
  - The payload is captured at acceptance, not recomputed from the shift register.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP; PARITY_ODD is ignored.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (tx_state_t).
  - Legal-range constants: DATA_BITS min/max, STOP_BITS max.
  - Parity function (even/odd XOR-reduce), also reused by the receiver.
- One natural sub-module, uart_baud_tick:
  - Parametrised CLKS_PER_BIT counter.
  - Inputs: sys_clk, reset, enable (clears when low).
  - Output: one-cycle tick on terminal count.
- The FSM and shift register stay in uart_tx_frame.

Test Plan:
- Use CLKS_PER_BIT=4.
- Reset release → tx=1, ready=1, busy=0, done=0.
- DATA_BITS=7, STOP_BITS=1, load one cycle with data_in=7'h55:
  - tx sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,1.
  - done pulses on cycle 36 after acceptance; ready high on cycle 37.
- load held high with data_in=7'h01 then 7'h7F:
  - Two frames separated by exactly 1 idle-high cycle.
  - Second frame carries 7'h7F; no third frame while load is low.
- Change data_in to 7'h00 mid-frame after accepting 7'h2A:
  - Serial bits still decode to 7'h2A.
  - load pulses while busy are ignored.
- Assert reset at data bit 3:
  - tx=1 next cycle, no done pulse.
  - A new load of 7'h11 transmits a correct frame.
- With UART_TX_PARITY_EN, PARITY_ODD=0, DATA_BITS=8, STOP_BITS=2, data 8'hA7 (five ones):
  - Parity bit = 1.
  - Frame = 12 bits = 48 cycles.
  - PARITY_ODD=1 gives parity bit 0.
